// File: rtl/seq_divider.sv
// Sequential restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Fixed latency: one operand-latch edge, WIDTH iteration edges, one result edge.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [1:0]       op_q;
    logic             neg_a;
    logic             neg_b;
    logic             div_zero;

    logic             accept;
    logic             last;
    logic             signed_in;
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] result_next;

    assign accept    = start && (state != CALC);
    assign last      = (count == CW'(WIDTH));
    assign signed_in = ~op[0];
    assign a_neg_in  = signed_in & dividend[WIDTH-1];
    assign b_neg_in  = signed_in & divisor[WIDTH-1];
    // Magnitudes are unsigned WIDTH bits, so the most negative value maps cleanly to 2^(WIDTH-1).
    assign a_mag     = a_neg_in ? -dividend : dividend;
    assign b_mag     = b_neg_in ? -divisor  : divisor;

    assign rem_shift = {rem, quo[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs};
    assign fits      = ~diff[WIDTH];

    // Division by zero forces an all-ones quotient; the remainder path already yields the dividend.
    assign q_fin       = div_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
    assign r_fin       = neg_a ? -rem : rem;
    assign result_next = op_q[1] ? r_fin : q_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? CALC : IDLE;
            CALC:    next_state = last ? DONE : CALC;
            DONE:    next_state = start ? CALC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            op_q     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            count    <= '0;
            quo      <= a_mag;
            rem      <= '0;
            dvs      <= b_mag;
            op_q     <= op;
            neg_a    <= a_neg_in;
            neg_b    <= b_neg_in;
            div_zero <= (divisor == '0);
        end else if (state == CALC) begin
            if (!last) begin
                count <= count + 1'b1;
                rem   <= fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                quo   <= {quo[WIDTH-2:0], fits};
            end else begin
                result <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider: a scoreboard queue of expected
// results and completion cycles is drained by a monitor watching done.
module tb_seq_divider;

    localparam int NUM_RANDOM = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        longint      due;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    exp_t   sbQ[$];
    exp_t   monE;
    longint cycle = 0;
    longint lastStamp = 0;
    int     checks = 0;
    int     errors = 0;

    vec_t dirVecs[12] = '{
        '{2'd0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
        '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
        '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1},
        '{2'd3, 32'd100,      32'd7,        32'd2},
        '{2'd1, 32'd5,        32'd0,        32'hFFFFFFFF},
        '{2'd3, 32'd5,        32'd0,        32'd5},
        '{2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
        '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0},
        '{2'd0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF},
        '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB},
        '{2'd1, 32'h80000000, 32'd2,        32'h40000000},
        '{2'd0, 32'h80000000, 32'd2,        32'hC0000000}
    };

    seq_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference semantics straight from the RISC-V rules, using 64-bit arithmetic.
    function automatic logic [31:0] refModel(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint r;
        logic [63:0] t;
        case (o)
            2'd0:    r = (b == 32'd0) ? -1 : sa / sb;
            2'd1:    r = (b == 32'd0) ? -1 : ua / ub;
            2'd2:    r = (b == 32'd0) ? sa : sa % sb;
            default: r = (b == 32'd0) ? ua : ua % ub;
        endcase
        t = r;
        return t[31:0];
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic launch(logic [1:0] o, logic [31:0] a, logic [31:0] b,
                          logic [31:0] expRes, string name);
        exp_t e;
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        lastStamp = cycle;
        e.res  = expRes;
        e.due  = cycle + 33;
        e.name = name;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(logic [1:0] o, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] expRes, string name,
                                 bit hold = 1'b0, bit releaseReset = 1'b0);
        @(negedge clk);
        if (releaseReset) rst_n = 1'b1;
        launch(o, a, b, expRes, name);
        if (!hold) begin
            start    = 1'b0;
            op       = 2'($urandom_range(0, 3));
            dividend = $urandom;
            divisor  = $urandom;
        end
    endtask

    task automatic waitDone(string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s_timeout: got no done, expected done within 40 cycles", name);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            checkOutput("doneWithPending", 64'(sbQ.size() != 0), 64'd1);
            if (sbQ.size() != 0) begin
                monE = sbQ.pop_front();
                checkOutput({monE.name, "_result"}, 64'(result), 64'(monE.res));
                checkOutput({monE.name, "_latency"}, cycle, monE.due);
            end
        end
    end

    initial begin
        int          n;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        #12;
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetDone", 64'(done), 64'd0);
        checkOutput("resetResult", 64'(result), 64'd0);

        // First start lands on the first edge after reset release.
        applyStimulus(2'd1, 32'd100, 32'd7, 32'd14, "divu_100_7", 1'b0, 1'b1);
        n = 0;
        repeat (32) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        checkOutput("busyIterCycles", 64'(n), 64'd32);
        @(negedge clk);
        checkOutput("busyBeforeResult", 64'(busy), 64'd1);
        checkOutput("doneEarly", 64'(done), 64'd0);
        waitDone("divu_100_7");
        checkOutput("busyInDone", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("resultHold", 64'(result), 64'd14);
        checkOutput("doneCleared", 64'(done), 64'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(dirVecs[i].o, dirVecs[i].a, dirVecs[i].b, dirVecs[i].r,
                          $sformatf("directed%0d", i));
            waitDone($sformatf("directed%0d", i));
        end

        // A second start at E10 must be ignored.
        applyStimulus(2'd1, 32'd1000, 32'd3, 32'd333, "ignoreStart");
        repeat (10) @(negedge clk);
        op       = 2'd0;
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyAfterIgnoredStart", 64'(busy), 64'd1);
        waitDone("ignoreStart");

        // Asynchronous reset at E15 aborts the operation.
        applyStimulus(2'd3, 32'd12345, 32'd100, 32'd45, "aborted");
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortDone", 64'(done), 64'd0);
        checkOutput("abortResult", 64'(result), 64'd0);
        void'(sbQ.pop_back());
        repeat (3) @(negedge clk);
        applyStimulus(2'd3, 32'd1000, 32'd7, 32'd6, "afterReset", 1'b0, 1'b1);
        waitDone("afterReset");

        // Start held high through the done cycle chains a second operation.
        applyStimulus(2'd1, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, "held1", 1'b1);
        waitDone("held1");
        launch(2'd2, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, "held2");
        start = 1'b0;
        waitDone("held2");

        @(negedge clk);
        for (int i = 0; i < NUM_RANDOM; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
                3: b = $urandom_range(1, 7);
                4: b = 32'hFFFFFFFF - $urandom_range(0, 7);
                default: ;
            endcase
            launch(o, a, b, refModel(o, a, b), "random");
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
            waitDone("random");
        end

        repeat (3) @(negedge clk);
        checkOutput("pendingAtEnd", 64'(sbQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
